// File: rtl/traffic_conflict_monitor_if.sv
// Controller-to-lamp bus seen by the conflict monitor.
// fault_count exists only when TRAFFIC_MON_FAULT_CNT_EN is defined.
interface traffic_conflict_monitor_if;
  logic [2:0] red_in;
  logic [2:0] yellow_in;
  logic [2:0] green_in;
  logic       fault_clr;
  logic [2:0] red_out;
  logic [2:0] yellow_out;
  logic [2:0] green_out;
  logic       fault;
  logic [2:0] fault_code;
`ifdef TRAFFIC_MON_FAULT_CNT_EN
  logic [7:0] fault_count;
`endif

  modport master (
    output red_in, yellow_in, green_in, fault_clr,
    input  red_out, yellow_out, green_out, fault, fault_code
`ifdef TRAFFIC_MON_FAULT_CNT_EN
    , input fault_count
`endif
  );

  modport slave (
    input  red_in, yellow_in, green_in, fault_clr,
    output red_out, yellow_out, green_out, fault, fault_code
`ifdef TRAFFIC_MON_FAULT_CNT_EN
    , output fault_count
`endif
  );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the junction controller and the lamp drivers: passes legal lamp
// words, latches illegal/conflicting/stalled conditions and flashes red until cleared.
// Optional FAULT-entry counter enabled by defining TRAFFIC_MON_FAULT_CNT_EN.
module traffic_conflict_monitor #(
  parameter int unsigned CONFLICT_FILT = 3,
  parameter int unsigned WDOG_MAX      = 1024,
  parameter int unsigned FLASH_DIV     = 8,
  parameter int unsigned STARTUP_CYC   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  traffic_conflict_monitor_if.slave   mon
);

  localparam int unsigned FILT_W = $clog2(CONFLICT_FILT + 1);
  localparam int unsigned WD_W   = $clog2(WDOG_MAX + 1);
  localparam int unsigned FL_W   = $clog2(FLASH_DIV + 1);
  localparam int unsigned SU_W   = $clog2(STARTUP_CYC + 1);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SU_W-1:0]    su_q, su_d;
  logic [FILT_W-1:0]  filt_q, filt_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [FL_W-1:0]    fl_q, fl_d;
  logic               phase_q, phase_d;
  logic [8:0]         prev_q, prev_d;
  logic [1:0]         cause_q, cause_d;
  logic [2:0]         red_q, red_d;
  logic [2:0]         yellow_q, yellow_d;
  logic [2:0]         green_q, green_d;
  logic               fault_q, fault_d;
  logic [2:0]         code_q, code_d;
`ifdef TRAFFIC_MON_FAULT_CNT_EN
  logic [7:0]         cnt_q, cnt_d;
`endif

  // Per-sample legality checks
  logic [8:0]        word;
  logic [2:0]        one_hot;
  logic [2:0]        go;
  logic              lamp_err;
  logic              conflict;
  logic              viol;
  logic [1:0]        cause_run;

  assign word      = {mon.red_in, mon.yellow_in, mon.green_in};
  assign one_hot   = (mon.red_in ^ mon.yellow_in ^ mon.green_in) &
                     ~(mon.red_in & mon.yellow_in & mon.green_in);
  assign go        = mon.yellow_in | mon.green_in;
  assign lamp_err  = ~&one_hot;
  assign conflict  = (go[0] & go[1]) | (go[0] & go[2]) | (go[1] & go[2]);
  assign viol      = lamp_err | conflict;
  assign cause_run = cause_q | {conflict, lamp_err};

  // Saturating counter increments and trip conditions
  logic [SU_W-1:0]   su_inc;
  logic [FILT_W-1:0] filt_inc;
  logic [WD_W-1:0]   wd_inc;
  logic [FL_W-1:0]   fl_inc;
  logic              filt_trip;
  logic              wd_trip;

  assign su_inc    = (su_q == SU_W'(STARTUP_CYC)) ? su_q : su_q + SU_W'(1);
  assign filt_inc  = (filt_q == FILT_W'(CONFLICT_FILT)) ? filt_q : filt_q + FILT_W'(1);
  assign wd_inc    = (word != prev_q) ? '0 :
                     ((wd_q == WD_W'(WDOG_MAX)) ? wd_q : wd_q + WD_W'(1));
  assign fl_inc    = (fl_q == FL_W'(FLASH_DIV)) ? fl_q : fl_q + FL_W'(1);
  assign filt_trip = viol && (filt_inc == FILT_W'(CONFLICT_FILT));
  assign wd_trip   = (wd_inc == WD_W'(WDOG_MAX));

  always_comb begin
    state_d  = state_q;
    su_d     = su_q;
    filt_d   = filt_q;
    wd_d     = wd_q;
    fl_d     = fl_q;
    phase_d  = phase_q;
    prev_d   = word;
    cause_d  = cause_q;
    red_d    = red_q;
    yellow_d = yellow_q;
    green_d  = green_q;
    fault_d  = fault_q;
    code_d   = code_q;
`ifdef TRAFFIC_MON_FAULT_CNT_EN
    cnt_d    = cnt_q;
`endif

    unique case (state_q)
      ST_STARTUP: begin
        red_d    = 3'b111;
        yellow_d = 3'b000;
        green_d  = 3'b000;
        fault_d  = 1'b0;
        filt_d   = '0;
        wd_d     = '0;
        cause_d  = '0;
        if (su_inc == SU_W'(STARTUP_CYC)) begin
          state_d = ST_PASS;
          su_d    = '0;
        end else begin
          su_d    = su_inc;
        end
      end

      ST_PASS: begin
        wd_d = wd_inc;
        if (viol) begin
          filt_d  = filt_inc;
          cause_d = cause_run;
        end else begin
          filt_d   = '0;
          cause_d  = '0;
          red_d    = mon.red_in;
          yellow_d = mon.yellow_in;
          green_d  = mon.green_in;
        end
        // Filter expiry and watchdog may coincide; both contribute cause bits
        if (filt_trip || wd_trip) begin
          state_d  = ST_FAULT;
          code_d   = {wd_trip, filt_trip ? cause_run : 2'b00};
          fault_d  = 1'b1;
          red_d    = 3'b111;
          yellow_d = 3'b000;
          green_d  = 3'b000;
          phase_d  = 1'b1;
          fl_d     = '0;
`ifdef TRAFFIC_MON_FAULT_CNT_EN
          cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
`endif
        end
      end

      ST_FAULT: begin
        if (fl_inc == FL_W'(FLASH_DIV)) begin
          fl_d    = '0;
          phase_d = ~phase_q;
        end else begin
          fl_d    = fl_inc;
        end
        red_d    = {3{phase_d}};
        yellow_d = 3'b000;
        green_d  = 3'b000;
        fault_d  = 1'b1;
        // Leaving FAULT is only allowed while the controller is presenting a legal word
        if (mon.fault_clr && !viol) begin
          state_d = ST_STARTUP;
          code_d  = 3'b000;
          fault_d = 1'b0;
          red_d   = 3'b111;
          su_d    = '0;
          filt_d  = '0;
          wd_d    = '0;
          cause_d = '0;
        end
      end

      default: begin
        state_d = ST_STARTUP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_STARTUP;
      su_q     <= '0;
      filt_q   <= '0;
      wd_q     <= '0;
      fl_q     <= '0;
      phase_q  <= 1'b0;
      prev_q   <= '0;
      cause_q  <= '0;
      red_q    <= 3'b111;
      yellow_q <= 3'b000;
      green_q  <= 3'b000;
      fault_q  <= 1'b0;
      code_q   <= 3'b000;
`ifdef TRAFFIC_MON_FAULT_CNT_EN
      cnt_q    <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      su_q     <= su_d;
      filt_q   <= filt_d;
      wd_q     <= wd_d;
      fl_q     <= fl_d;
      phase_q  <= phase_d;
      prev_q   <= prev_d;
      cause_q  <= cause_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
`ifdef TRAFFIC_MON_FAULT_CNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign mon.red_out    = red_q;
  assign mon.yellow_out = yellow_q;
  assign mon.green_out  = green_q;
  assign mon.fault      = fault_q;
  assign mon.fault_code = code_q;
`ifdef TRAFFIC_MON_FAULT_CNT_EN
  assign mon.fault_count = cnt_q;
`endif

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor with hand-computed expected lamp words.
// fault_count checks are active when TRAFFIC_MON_FAULT_CNT_EN is defined.
module tb_traffic_conflict_monitor;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   exp_cnt;

  traffic_conflict_monitor_if bus ();

  traffic_conflict_monitor dut (
    .clk   (clk),
    .reset (rst_n),
    .mon   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {red, yellow, green}, bit n = approach n
  localparam logic [8:0] W_A     = {3'b110, 3'b000, 3'b001};  // g0 r1 r2
  localparam logic [8:0] W_B     = {3'b110, 3'b001, 3'b000};  // y0 r1 r2
  localparam logic [8:0] W_C     = {3'b101, 3'b000, 3'b010};  // r0 g1 r2
  localparam logic [8:0] CONF    = {3'b100, 3'b000, 3'b011};  // g0 g1 r2
  localparam logic [8:0] DARK1   = {3'b101, 3'b000, 3'b000};  // r0 dark1 r2
  localparam logic [8:0] DG      = {3'b000, 3'b000, 3'b101};  // g0 dark1 g2
  localparam logic [8:0] ALL_RED = {3'b111, 3'b000, 3'b000};
  localparam logic [8:0] ALL_OFF = {3'b000, 3'b000, 3'b000};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [8:0] w);
    bus.red_in    = w[8:6];
    bus.yellow_in = w[5:3];
    bus.green_in  = w[2:0];
  endtask

  task automatic chk(input string tag, input logic [8:0] w, input logic f, input logic [2:0] code);
    logic [12:0] obs;
    logic [12:0] exp;
    obs = {bus.red_out, bus.yellow_out, bus.green_out, bus.fault, bus.fault_code};
    exp = {w, f, code};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef TRAFFIC_MON_FAULT_CNT_EN
    vectors++;
    assert (bus.fault_count === 8'(exp_cnt)) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, bus.fault_count, 8'(exp_cnt));
    end
`endif
  endtask

  // 16 all-red cycles, then the held legal word one cycle after it is sampled
  task automatic startup_run(input logic [8:0] w);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("startup_red", ALL_RED, 1'b0, 3'b000);
    end
    tick();
    chk("startup_pass", w, 1'b0, 3'b000);
  endtask

  task automatic clear_fault();
    set_word(W_A);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("clr_to_startup", ALL_RED, 1'b0, 3'b000);
    chk_cnt("cnt_after_clr");
    startup_run(W_A);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_cnt     = 0;
    rst_n       = 1'b0;
    bus.fault_clr = 1'b0;
    set_word(W_A);
    tick();
    tick();
    chk("reset_vals", ALL_RED, 1'b0, 3'b000);
    chk_cnt("reset_cnt");
    rst_n = 1'b1;
    startup_run(W_A);

    // Pass-through latency and fault_clr outside FAULT
    set_word(W_B);
    tick();
    chk("pass_b", W_B, 1'b0, 3'b000);
    set_word(W_C);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("clr_in_pass", W_C, 1'b0, 3'b000);

    // Two violating samples: held, then resume
    set_word(CONF);
    tick();
    chk("filt1_hold", W_C, 1'b0, 3'b000);
    tick();
    chk("filt2_hold", W_C, 1'b0, 3'b000);
    set_word(W_A);
    tick();
    chk("filt_resume", W_A, 1'b0, 3'b000);

    // Three violating samples: CONFLICT fault and flashing
    set_word(CONF);
    tick();
    chk("conf1_hold", W_A, 1'b0, 3'b000);
    tick();
    chk("conf2_hold", W_A, 1'b0, 3'b000);
    tick();
    chk("conf_fault", ALL_RED, 1'b1, 3'b010);
    repeat (7) tick();
    chk("flash_on_end", ALL_RED, 1'b1, 3'b010);
    tick();
    chk("flash_off", ALL_OFF, 1'b1, 3'b010);
    repeat (7) tick();
    chk("flash_off_end", ALL_OFF, 1'b1, 3'b010);
    tick();
    chk("flash_on2", ALL_RED, 1'b1, 3'b010);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("clr_with_viol", ALL_RED, 1'b1, 3'b010);
    exp_cnt = 1;
    chk_cnt("cnt_conf");
    clear_fault();

    // Dark approach: LAMP_ERR only
    set_word(DARK1);
    tick();
    chk("dark1_hold", W_A, 1'b0, 3'b000);
    tick();
    chk("dark2_hold", W_A, 1'b0, 3'b000);
    tick();
    chk("dark_fault", ALL_RED, 1'b1, 3'b001);
    exp_cnt = 2;
    clear_fault();

    // Causes accumulate over one violating run
    set_word(CONF);
    tick();
    set_word(DARK1);
    tick();
    chk("mixed_hold", W_A, 1'b0, 3'b000);
    tick();
    chk("mixed_fault", ALL_RED, 1'b1, 3'b011);
    exp_cnt = 3;
    clear_fault();

    // Dark plus two greens in the same word
    set_word(DG);
    repeat (3) tick();
    chk("dg_fault", ALL_RED, 1'b1, 3'b011);
    exp_cnt = 4;
    clear_fault();

    // Watchdog: a change at sample 1023 restarts it, then 1024 unchanged edges trip it
    set_word(W_B);
    tick();
    chk("wd_start", W_B, 1'b0, 3'b000);
    repeat (1022) tick();
    set_word(W_C);
    tick();
    chk("wd_change_1023", W_C, 1'b0, 3'b000);
    repeat (1023) tick();
    chk("wd_hold_1023", W_C, 1'b0, 3'b000);
    tick();
    chk("wd_fault", ALL_RED, 1'b1, 3'b100);
    exp_cnt = 5;
    chk_cnt("cnt_wd");
    clear_fault();

    // Asynchronous reset in the middle of PASS
    set_word(W_B);
    tick();
    chk("pre_reset", W_B, 1'b0, 3'b000);
    rst_n = 1'b0;
    #1;
    chk("async_reset", ALL_RED, 1'b0, 3'b000);
    exp_cnt = 0;
    chk_cnt("cnt_reset");
    tick();
    rst_n = 1'b1;
    startup_run(W_B);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
